// File: rtl/v8cpu_pkg.sv
// Shared constants for the v8cpu ALU: opcode encodings and flag-byte bit positions.
package v8cpu_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBB = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;
    localparam logic [3:0] OP_ROL = 4'd11;
    localparam logic [3:0] OP_ROR = 4'd12;
    localparam logic [3:0] OP_INC = 4'd13;
    localparam logic [3:0] OP_DEC = 4'd14;
    localparam logic [3:0] OP_CMP = 4'd15;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/v8cpu_shifter.sv
// Single-bit shift/rotate unit; also reports the bit that falls off the end.
module v8cpu_shifter
    import v8cpu_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] result,
    output logic              shiftOut
);

    logic signed [DATA_W-1:0] aSigned;

    assign aSigned = signed'(a);

    always_comb begin
        result   = a;
        shiftOut = 1'b0;
        case (op)
            OP_SHL: begin
                result   = {a[DATA_W-2:0], 1'b0};
                shiftOut = a[DATA_W-1];
            end
            OP_SHR: begin
                result   = {1'b0, a[DATA_W-1:1]};
                shiftOut = a[0];
            end
            OP_SAR: begin
                result   = unsigned'(aSigned >>> 1);
                shiftOut = a[0];
            end
            OP_ROL: begin
                result   = {a[DATA_W-2:0], a[DATA_W-1]};
                shiftOut = a[DATA_W-1];
            end
            OP_ROR: begin
                result   = {a[0], a[DATA_W-1:1]};
                shiftOut = a[0];
            end
            default: begin
                result   = a;
                shiftOut = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/v8_cpu_alu.sv
// v8cpu ALU: combinational result/flag generation plus a registered status-flag copy.
module v8_cpu_alu
    import v8cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] flags,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] newFlags,
    output logic [DATA_W-1:0] flags_q
);

    logic [DATA_W-1:0] addB;
    logic              carryIn;
    logic              borrowIn;
    logic [DATA_W:0]   addRes;
    logic [DATA_W:0]   subRes;
    logic              addOvf;
    logic              subOvf;
    logic [DATA_W-1:0] shiftRes;
    logic              shiftOut;
    logic [DATA_W-1:0] flagSrc;
    logic              carryFlag;
    logic              ovfFlag;

    v8cpu_shifter uShifter (
        .op       (op),
        .a        (a),
        .result   (shiftRes),
        .shiftOut (shiftOut)
    );

    // INC/DEC reuse the adder/subtractor with an implicit operand of 1.
    assign addB     = (op == OP_INC || op == OP_DEC) ? 8'h01 : b;
    assign carryIn  = (op == OP_ADC) ? flags[FLAG_C] : 1'b0;
    assign borrowIn = (op == OP_SBB) ? flags[FLAG_C] : 1'b0;

    assign addRes = {1'b0, a} + {1'b0, addB} + {{DATA_W{1'b0}}, carryIn};
    assign subRes = {1'b0, a} - {1'b0, addB} - {{DATA_W{1'b0}}, borrowIn};

    assign addOvf = (a[DATA_W-1] == addB[DATA_W-1]) && (addRes[DATA_W-1] != a[DATA_W-1]);
    assign subOvf = (a[DATA_W-1] != addB[DATA_W-1]) && (subRes[DATA_W-1] != a[DATA_W-1]);

    // flagSrc is the value Z/N are judged on; it differs from c only for CMP.
    always_comb begin
        c         = a;
        flagSrc   = a;
        carryFlag = 1'b0;
        ovfFlag   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                c         = addRes[DATA_W-1:0];
                flagSrc   = addRes[DATA_W-1:0];
                carryFlag = addRes[DATA_W];
                ovfFlag   = addOvf;
            end
            OP_SUB, OP_SBB: begin
                c         = subRes[DATA_W-1:0];
                flagSrc   = subRes[DATA_W-1:0];
                carryFlag = subRes[DATA_W];
                ovfFlag   = subOvf;
            end
            OP_INC: begin
                c         = addRes[DATA_W-1:0];
                flagSrc   = addRes[DATA_W-1:0];
                carryFlag = flags[FLAG_C];
                ovfFlag   = addOvf;
            end
            OP_DEC: begin
                c         = subRes[DATA_W-1:0];
                flagSrc   = subRes[DATA_W-1:0];
                carryFlag = flags[FLAG_C];
                ovfFlag   = subOvf;
            end
            OP_CMP: begin
                c         = a;
                flagSrc   = subRes[DATA_W-1:0];
                carryFlag = subRes[DATA_W];
                ovfFlag   = subOvf;
            end
            OP_AND: begin
                c       = a & b;
                flagSrc = a & b;
            end
            OP_OR: begin
                c       = a | b;
                flagSrc = a | b;
            end
            OP_XOR: begin
                c       = a ^ b;
                flagSrc = a ^ b;
            end
            OP_NOT: begin
                c       = ~a;
                flagSrc = ~a;
            end
            OP_SHL: begin
                c         = shiftRes;
                flagSrc   = shiftRes;
                carryFlag = shiftOut;
                ovfFlag   = a[DATA_W-1] ^ a[DATA_W-2];
            end
            OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
                c         = shiftRes;
                flagSrc   = shiftRes;
                carryFlag = shiftOut;
            end
            default: begin
                c       = a;
                flagSrc = a;
            end
        endcase
    end

    assign newFlags = {flags[7:4], ovfFlag, flagSrc[DATA_W-1], carryFlag, (flagSrc == '0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= newFlags;
        end
    end

endmodule

// File: tb/tb_v8_cpu_alu.sv
// Directed self-checking bench for v8_cpu_alu using immediate assertions.
module tb_v8_cpu_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] flags;
    logic [7:0] c;
    logic [7:0] newFlags;
    logic [7:0] flags_q;

    int compared;
    int mismatched;

    v8_cpu_alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .op       (op),
        .flags    (flags),
        .c        (c),
        .newFlags (newFlags),
        .flags_q  (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    task automatic apply(input logic [3:0] opIn, input logic [7:0] aIn, input logic [7:0] bIn,
                         input logic [7:0] flagsIn);
        op    = opIn;
        a     = aIn;
        b     = bIn;
        flags = flagsIn;
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        a = 8'h00; b = 8'h00; op = 4'd0; flags = 8'h00;
        #2;

        apply(4'd0, 8'd12, 8'd24, 8'h00);
        check("add_c", c, 8'd36);
        check("add_f", newFlags, 8'h00);
        apply(4'd1, 8'd45, 8'd23, 8'h00);
        check("sub_c", c, 8'd22);
        check("sub_f", newFlags, 8'h00);
        apply(4'd2, 8'd200, 8'd100, 8'h00);
        check("and_c", c, 8'd64);
        check("and_f", newFlags, 8'h00);
        apply(4'd3, 8'd50, 8'd50, 8'h00);
        check("or_c", c, 8'd50);
        check("or_f", newFlags, 8'h00);
        apply(4'd4, 8'd75, 8'd125, 8'h00);
        check("xor_c", c, 8'd54);
        check("xor_f", newFlags, 8'h00);
        apply(4'd0, 8'd200, 8'd100, 8'h00);
        check("addc_c", c, 8'd44);
        check("addc_f", newFlags, 8'h02);
        apply(4'd0, 8'd100, 8'd100, 8'h00);
        check("addv_c", c, 8'd200);
        check("addv_f", newFlags, 8'h0C);
        apply(4'd1, 8'd5, 8'd5, 8'h00);
        check("subz_c", c, 8'd0);
        check("subz_f", newFlags, 8'h01);
        apply(4'd1, 8'd3, 8'd5, 8'h00);
        check("subb_c", c, 8'd254);
        check("subb_f", newFlags, 8'h06);
        apply(4'd5, 8'd1, 8'd1, 8'hF2);
        check("adc_c", c, 8'd3);
        check("adc_f", newFlags, 8'hF0);
        apply(4'd6, 8'd0, 8'd0, 8'h02);
        check("sbb_c", c, 8'hFF);
        check("sbb_f", newFlags, 8'h06);
        apply(4'd7, 8'h0F, 8'h00, 8'h02);
        check("not_c", c, 8'hF0);
        check("not_f", newFlags, 8'h04);
        apply(4'd8, 8'h81, 8'h00, 8'h00);
        check("shl_c", c, 8'h02);
        check("shl_f", newFlags, 8'h0A);
        apply(4'd9, 8'h81, 8'h00, 8'h00);
        check("shr_c", c, 8'h40);
        check("shr_f", newFlags, 8'h02);
        apply(4'd10, 8'h81, 8'h00, 8'h00);
        check("sar_c", c, 8'hC0);
        check("sar_f", newFlags, 8'h06);
        apply(4'd11, 8'h81, 8'h00, 8'h00);
        check("rol_c", c, 8'h03);
        check("rol_f", newFlags, 8'h02);
        apply(4'd12, 8'h01, 8'h00, 8'h00);
        check("ror_c", c, 8'h80);
        check("ror_f", newFlags, 8'h06);
        apply(4'd13, 8'hFF, 8'h00, 8'h02);
        check("inc_c", c, 8'h00);
        check("inc_f", newFlags, 8'h03);
        apply(4'd14, 8'h80, 8'h00, 8'h00);
        check("dec_c", c, 8'h7F);
        check("dec_f", newFlags, 8'h08);
        apply(4'd15, 8'd10, 8'd20, 8'h00);
        check("cmp_c", c, 8'd10);
        check("cmp_f", newFlags, 8'h06);

        // Flag register: held at zero through clock edges while in reset.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold", flags_q, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd0, 8'd255, 8'd1, 8'h00);
        check("add255_f", newFlags, 8'h03);
        @(posedge clk);
        #1;
        check("reg_load", flags_q, 8'h03);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", flags_q, 8'h00);
        check("rst_comb", newFlags, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
